ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_queue.sv | 91 +++++++++
 tb/tb_ir_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction register queue: circular FIFO with head-entry field decode.
// Optional macro IR_SEXT_EN: sign-extend imm for imm_ext (zero-extend otherwise).
module ir_queue #(
    parameter int IW    = 16,
    parameter int DEPTH = 2,
    parameter int XLEN  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [IW-1:0]              instruction,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 opcode,
    output logic                       m,
    output logic [2:0]                 rd,
    output logic [2:0]                 rs1,
    output logic [IW-12:0]             imm,
    output logic [XLEN-1:0]            imm_ext,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IMMW = IW - 11;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic [IW-1:0] head;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is never reset; a word pushed alongside flush or reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem[wr_ptr] <= instruction;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        opcode  = '0;
        m       = 1'b0;
        rd      = '0;
        rs1     = '0;
        imm     = '0;
        imm_ext = '0;
        if (out_valid) begin
            opcode = head[IW-1 -: 4];
            m      = head[IW-5];
            rd     = head[IW-6 -: 3];
            rs1    = head[IW-9 -: 3];
            imm    = head[IMMW-1:0];
`ifdef IR_SEXT_EN
            imm_ext = XLEN'($signed(head[IMMW-1:0]));
`else
            imm_ext = XLEN'(head[IMMW-1:0]);
`endif
        end
    end
endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue with a scoreboard of pushed words.
module tb_ir_queue;
    localparam int IW    = 16;
    localparam int DEPTH = 2;
    localparam int XLEN  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [IW-1:0] instruction;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    opcode;
    logic          m;
    logic [2:0]    rd;
    logic [2:0]    rs1;
    logic [4:0]    imm;
    logic [XLEN-1:0] imm_ext;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] sb [$];

    ir_queue #(.IW(IW), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .instruction(instruction),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .m(m),
        .rd(rd), .rs1(rs1), .imm(imm), .imm_ext(imm_ext),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] exp_ext(input logic [4:0] i);
`ifdef IR_SEXT_EN
        return {{(XLEN-5){i[4]}}, i};
`else
        return {{(XLEN-5){1'b0}}, i};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; instruction = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: count=%0d ov=%b ir=%b want 0 0 1",
                     count, out_valid, in_ready);
        end
        checks++;
        if ({opcode, m, rd, rs1, imm} !== 16'h0 || imm_ext !== '0) begin
            errors++;
            $display("FAIL reset_decode: fields=%h ext=%h want 0 0",
                     {opcode, m, rd, rs1, imm}, imm_ext);
        end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; instruction = 16'hF123; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || opcode !== 4'h0) begin
            errors++;
            $display("FAIL no_comb_path: ov=%b op=%h want 0 0", out_valid, opcode);
        end
        step();
        sb.push_back(16'hF123);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || count !== 2'd1) begin
            errors++;
            $display("FAIL push_latency: ov=%b count=%0d want 1 1", out_valid, count);
        end
        checks++;
        if (opcode !== 4'b1111 || m !== 1'b0 || rd !== 3'b001 ||
            rs1 !== 3'b001 || imm !== 5'b00011) begin
            errors++;
            $display("FAIL f123_fields: op=%b m=%b rd=%b rs1=%b imm=%b want 1111 0 001 001 00011",
                     opcode, m, rd, rs1, imm);
        end
        checks++;
        if (imm_ext !== 16'h0003) begin
            errors++;
            $display("FAIL f123_ext: got %h want 0003", imm_ext);
        end
    endtask

    task automatic test_full();
        logic [IW-1:0] exp;
        in_valid = 1'b1; instruction = 16'hA456;
        step();
        sb.push_back(16'hA456);
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: count=%0d ir=%b want 2 0", count, in_ready);
        end
        instruction = 16'h1234;
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin
            errors++;
            $display("FAIL push_when_full: count=%0d want 2", count);
        end
        out_ready = 1'b1;
        #1;
        exp = sb.pop_front();
        checks++;
        if ({opcode, m, rd, rs1, imm} !== exp) begin
            errors++;
            $display("FAIL pop_head: got %h want %h", {opcode, m, rd, rs1, imm}, exp);
        end
        // Full with pop: push must still be refused this cycle.
        in_valid = 1'b1; instruction = 16'h1234;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_ready: ir=%b want 0", in_ready);
        end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 2'd1 || opcode !== 4'b1010 || m !== 1'b0 ||
            rd !== 3'b100 || rs1 !== 3'b010 || imm !== 5'b10110) begin
            errors++;
            $display("FAIL a456_fields: count=%0d op=%b m=%b rd=%b rs1=%b imm=%b want 1 1010 0 100 010 10110",
                     count, opcode, m, rd, rs1, imm);
        end
        checks++;
`ifdef IR_SEXT_EN
        if (imm_ext !== 16'hFFF6) begin
            errors++;
            $display("FAIL a456_ext: got %h want fff6", imm_ext);
        end
`else
        if (imm_ext !== 16'h0016) begin
            errors++;
            $display("FAIL a456_ext: got %h want 0016", imm_ext);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] exp;
        logic [IW-1:0] w;
        for (int i = 0; i < 2*DEPTH+1; i++) begin
            w = IW'($urandom);
            in_valid = 1'b1; out_ready = 1'b1; instruction = w;
            #1;
            exp = sb.pop_front();
            checks++;
            if ({opcode, m, rd, rs1, imm} !== exp || imm_ext !== exp_ext(exp[4:0])) begin
                errors++;
                $display("FAIL b2b_head[%0d]: got %h/%h want %h/%h", i,
                         {opcode, m, rd, rs1, imm}, imm_ext, exp, exp_ext(exp[4:0]));
            end
            step();
            sb.push_back(w);
            checks++;
            if (count !== 2'd1) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got %0d want 1", i, count);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if ({opcode, m, rd, rs1, imm} !== sb[0]) begin
            errors++;
            $display("FAIL b2b_last: got %h want %h", {opcode, m, rd, rs1, imm}, sb[0]);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; instruction = 16'h5A5A;
        step();
        sb.push_back(16'h5A5A);
        checks++;
        if (count !== 2'd2) begin
            errors++;
            $display("FAIL flush_setup: count=%0d want 2", count);
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instruction = 16'h7777;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {opcode, m, rd, rs1, imm} !== 16'h0 || imm_ext !== '0) begin
            errors++;
            $display("FAIL flush_state: count=%0d ov=%b ir=%b fields=%h ext=%h want 0 0 1 0 0",
                     count, out_valid, in_ready, {opcode, m, rd, rs1, imm}, imm_ext);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty: count=%0d ov=%b want 0 0", count, out_valid);
        end
        // Simultaneous push and pop while empty: only the push lands.
        in_valid = 1'b1; out_ready = 1'b1; instruction = 16'h3C3C;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 2'd1 || {opcode, m, rd, rs1, imm} !== 16'h3C3C) begin
            errors++;
            $display("FAIL empty_push_pop: count=%0d head=%h want 1 3c3c",
                     count, {opcode, m, rd, rs1, imm});
        end
    endtask

    task automatic test_reset_full();
        in_valid = 1'b1; instruction = 16'h1111;
        step();
        checks++;
        if (count !== 2'd2) begin
            errors++;
            $display("FAIL rst_full_setup: count=%0d want 2", count);
        end
        reset = 1'b1; instruction = 16'h2222;
        step();
        reset = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            {opcode, m, rd, rs1, imm} !== 16'h0) begin
            errors++;
            $display("FAIL rst_full: count=%0d ir=%b ov=%b fields=%h want 0 1 0 0",
                     count, in_ready, out_valid, {opcode, m, rd, rs1, imm});
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
